adder_chunked_seq: RTL and testbench
====================================

ADDER_CHUNKED_SEQ -- requirements
Module: adder_chunked_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 2: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK (N = WIDTH/CHUNK).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH+1  result; sum[WIDTH] is carry-out (for sub: 1 = no borrow).
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-015 in_ready SHALL be 1 only in IDLE; accept occurs on a clk edge with in_valid && in_ready.
REQ-016 On accept (cycle k): latch a, b (b inverted if sub), sub; chunk index := 0; carry := sub; clear sum; go to RUN.
REQ-017 In RUN, each cycle SHALL add chunk [idx*CHUNK +: CHUNK] of latched A, latched (possibly inverted) B and carry with one CHUNK-bit adder, write the CHUNK result bits into sum at the same slice, register carry-out, increment idx.
REQ-018 When idx == N-1 is processed, final carry SHALL be written to sum[WIDTH] and FSM SHALL go to DONE.
REQ-019 out_valid SHALL rise at cycle k+N+1 and stay high in DONE.
REQ-020 While out_valid && !out_ready, sum SHALL be held stable.
REQ-021 On out_valid && out_ready, FSM SHALL go to IDLE; in_ready rises the next cycle; out_valid drops the same edge.
REQ-022 Throughput with out_ready tied high: one result per N+2 cycles.
REQ-023 Changes on a, b, sub, in_valid during RUN/DONE SHALL have no effect.
REQ-024 Result SHALL equal (A + B) mod 2^(WIDTH+1) for add, and A + ~B + 1 truncated to WIDTH+1 bits for sub.
REQ-025 CHUNK == WIDTH (N = 1) SHALL be supported: out_valid at cycle k+2.
REQ-026 out_ready while not in DONE SHALL be ignored.

Reset
REQ-027 rst asserted SHALL immediately force IDLE, in_ready=1 (after release, not while rst high: in_ready=0 during rst), out_valid=0, busy=0, sum=0, carry=0, idx=0.
REQ-028 rst mid-RUN or mid-DONE SHALL discard the partial/held result; no out_valid is produced for that request.
REQ-029 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-030 a=0xFF, b=0x01, sub=0, out_ready=1 -> out_valid at k+5, sum=0x100, busy high k+1..k+5.
REQ-031 a=0x05, b=0x07, sub=1 -> sum=0x0FE; a=0x07, b=0x05, sub=1 -> sum=0x102.
REQ-032 Result ready, out_ready held 0 for 10 cycles while a/b toggle -> out_valid and sum stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed at k+2 of a 0xAA+0x55 request -> all outputs zero immediately, no out_valid; next request 0x10+0x20 -> sum=0x030.
REQ-034 WIDTH=4, CHUNK=2, exhaustive a,b in 0..15, both sub values -> matches REQ-024 (e.g. 0xF+0xF=0x1E); repeat WIDTH=8, CHUNK=8 random.
REQ-035 Back-to-back in_valid high with out_ready=1 -> accepts spaced exactly N+2 cycles apart, no request dropped or duplicated.

Source files
------------

// File: rtl/adder_chunked_seq.sv
// adder_chunked_seq
//   Sequential ripple adder/subtractor. An accepted operand pair is added
//   CHUNK bits per clock, LSB chunk first, through a single CHUNK-bit adder.
//   The result, including the carry-out, is held until the consumer takes it.
//
// Parameters
//   WIDTH  operand width in bits (>= 2)
//   CHUNK  bits added per cycle; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept operands (IDLE only, low while rst is high)
//   a, b       unsigned operands
//   sub        0 = a+b, 1 = a-b (computed as a + ~b + 1)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   sum        WIDTH+1 bit result; sum[WIDTH] is carry-out (sub: 1 = no borrow)
//   busy       high while a request is being computed or held
module adder_chunked_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : gen_bad_cfg
    $error("adder_chunked_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             idle_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK:0]   step;

  // One CHUNK-bit add with carry-in; the MSB of the result is the carry-out.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  always_comb step = chunk_add(a_q[idx*CHUNK +: CHUNK], b_q[idx*CHUNK +: CHUNK], carry);

  // idle_q is the registered ready flag; it is masked by rst so the port
  // reads 0 during reset yet is already 1 on the first edge after release.
  assign in_ready = idle_q & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idle_q    <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= RUN;
            idle_q <= 1'b0;
            busy   <= 1'b1;
            sum    <= '0;
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            carry  <= sub;
            idx    <= '0;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= step[CHUNK-1:0];
          carry                   <= step[CHUNK];
          if (idx == LAST) begin
            sum[WIDTH] <= step[CHUNK];
            idx        <= '0;
            state      <= DONE;
            out_valid  <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idle_q    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand latches need no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && in_valid) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

endmodule

// File: tb/tb_adder_chunked_seq.sv
// tb_adder_chunked_seq
//   Scoreboard bench for adder_chunked_seq. Accepted requests push the
//   arithmetic expectation; a monitor pops and compares on each result
//   handshake. Main instance WIDTH=8/CHUNK=2 gets directed and random traffic;
//   two extra instances cover WIDTH=4/CHUNK=2 exhaustively and WIDTH=8/CHUNK=8
//   randomly.
module tb_adder_chunked_seq;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit or_rand = 0;
  bit or_val  = 1;
  bit b2b     = 0;

  int unsigned expq[$];
  int          accq[$];

  adder_chunked_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // Reference: plain unsigned arithmetic modulo 2^(w+1).
  function automatic int unsigned model(input int unsigned x, input int unsigned y,
                                        input bit s, input int w);
    if (s) return (x + (1 << w) - y) % (1 << (w + 1));
    return (x + y) % (1 << (w + 1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = or_rand ? 1'($urandom) : or_val;
    end
  end

  // Monitor and accept watcher for the main instance.
  initial begin : mon
    bit          prev_ov;
    logic [W:0]  held;
    int          last_acc;
    prev_ov  = 0;
    held     = '0;
    last_acc = -1;
    forever begin
      @(negedge clk);
      if (!b2b) last_acc = -1;
      if (rst) begin
        expq.delete();
        accq.delete();
        prev_ov = 0;
      end else begin
        if (out_valid) begin
          if (!prev_ov) begin
            if (accq.size() == 0) fail_now("unexpected_out_valid");
            else chk("latency", 64'(cyc - accq[0]), 64'(N));
            held = sum;
          end else begin
            chk("sum_hold", 64'(sum), 64'(held));
          end
          if (out_ready) begin
            if (expq.size() == 0) fail_now("unexpected_result");
            else begin
              chk("result", 64'(sum), 64'(expq.pop_front()));
              void'(accq.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          expq.push_back(model(a, b, sub, W));
          accq.push_back(cyc + 1);
          if (b2b && last_acc >= 0) chk("b2b_spacing", 64'(cyc + 1 - last_acc), 64'(N + 2));
          last_acc = cyc + 1;
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit r;
    int g;
    a = x; b = y; sub = s; in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      g++;
    end while (!r && g < 200);
    if (!r) fail_now("issue_timeout");
    #1;
    in_valid = 1'b0;
    // Scribble on the inputs while the request is in flight.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((expq.size() != 0 || !in_ready) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) fail_now("wait_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  // Extra configurations: 4/2 exhaustive, 8/8 random.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_cfg
    localparam int XW  = (gi == 0) ? 4 : 8;
    localparam int XC  = (gi == 0) ? 2 : 8;
    localparam int XN  = XW / XC;
    localparam int NUM = (gi == 0) ? 512 : 300;

    logic          xrst;
    logic          xiv;
    logic          xir;
    logic [XW-1:0] xa;
    logic [XW-1:0] xb;
    logic          xsb;
    logic          xov;
    logic          xordy;
    logic [XW:0]   xs;
    logic          xbz;
    bit            done;
    int unsigned   q[$];
    int            qacc[$];

    adder_chunked_seq #(.WIDTH(XW), .CHUNK(XC)) u_dut (
      .clk(clk), .rst(xrst), .in_valid(xiv), .in_ready(xir),
      .a(xa), .b(xb), .sub(xsb), .out_valid(xov), .out_ready(xordy),
      .sum(xs), .busy(xbz)
    );

    initial begin
      xordy = 1'b0;
      forever begin
        @(posedge clk);
        #1 xordy = 1'($urandom);
      end
    end

    initial begin : xmon
      bit prev;
      prev = 0;
      forever begin
        @(negedge clk);
        if (!xrst) begin
          if (xov && !prev) begin
            if (qacc.size() == 0) fail_now($sformatf("cfg%0d_unexpected_valid", gi));
            else chk($sformatf("cfg%0d_latency", gi), 64'(cyc - qacc[0]), 64'(XN));
          end
          if (xov && xordy) begin
            if (q.size() == 0) fail_now($sformatf("cfg%0d_unexpected_result", gi));
            else begin
              chk($sformatf("cfg%0d_result a=%0h b=%0h", gi, u_dut.a_q, xa), 64'(xs), 64'(q.pop_front()));
              void'(qacc.pop_front());
            end
          end
          if (xiv && xir) begin
            q.push_back(model(xa, xb, xsb, XW));
            qacc.push_back(cyc + 1);
          end
          prev = xov;
        end
      end
    end

    initial begin : xdrv
      bit r;
      int g;
      done = 0;
      xrst = 1'b1; xiv = 1'b0; xa = '0; xb = '0; xsb = 1'b0;
      repeat (3) @(posedge clk);
      #1 xrst = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        if (gi == 0) begin
          xa  = XW'(i & 15);
          xb  = XW'((i >> 4) & 15);
          xsb = 1'((i >> 8) & 1);
        end else begin
          xa  = XW'($urandom);
          xb  = XW'($urandom);
          xsb = 1'($urandom);
        end
        xiv = 1'b1;
        g = 0;
        do begin
          @(negedge clk);
          r = xir;
          @(posedge clk);
          g++;
        end while (!r && g < 200);
        if (!r) fail_now($sformatf("cfg%0d_issue_timeout", gi));
        #1 xiv = 1'b0;
      end
      g = 0;
      while ((q.size() != 0 || !xir) && g < 300) begin
        @(negedge clk);
        g++;
      end
      if (g >= 300) fail_now($sformatf("cfg%0d_drain_timeout", gi));
      done = 1;
    end
  end

  initial begin : main
    bit r;
    int g;
    int cnt;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // 0xFF + 0x01, busy window.
    issue(8'hFF, 8'h01, 1'b0);
    for (int j = 0; j < N + 1; j++) begin
      @(negedge clk);
      chk($sformatf("busy_high_%0d", j + 1), 64'(busy), 64'(1));
    end
    @(negedge clk);
    chk("busy_low_after", 64'(busy), 64'(0));
    chk("in_ready_after", 64'(in_ready), 64'(1));
    wait_idle();

    // Subtractions with and without borrow.
    issue(8'h05, 8'h07, 1'b1);
    wait_idle();
    issue(8'h07, 8'h05, 1'b1);
    wait_idle();

    // Held result under back-pressure while inputs toggle.
    or_val = 0;
    issue(8'h3C, 8'h0F, 1'b0);
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) fail_now("hold_wait_timeout");
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1 a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    or_val = 1;
    g = 0;
    while (out_valid && g < 4) begin
      @(negedge clk);
      g++;
    end
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_in_ready", 64'(in_ready), 64'(1));
    wait_idle();

    // Reset mid-RUN discards the request.
    issue(8'hAA, 8'h55, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_sum", 64'(sum), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(8'h10, 8'h20, 1'b0);
    wait_idle();

    // Back-to-back requests with out_ready high.
    b2b = 1;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    cnt = 0;
    g = 0;
    while (cnt < 8 && g < 200) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      g++;
      if (r) begin
        cnt++;
        #1 a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end
    end
    if (cnt < 8) fail_now("b2b_timeout");
    in_valid = 1'b0;
    wait_idle();
    b2b = 0;

    // Random traffic with random back-pressure.
    or_rand = 1;
    repeat (150) issue(W'($urandom), W'($urandom), 1'($urandom));
    wait_idle();
    or_rand = 0;

    g = 0;
    while (!(gen_cfg[0].done && gen_cfg[1].done) && g < 20000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 20000) fail_now("cfg_done_timeout");
    chk("main_queue_empty", 64'(expq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
